// File: rtl/input_deserializer_pkg.sv
// Shared width definitions so the input deserializer and the output serializer
// agree on beat and frame sizes.
package input_deserializer_pkg;

   localparam int IN_WIDTH_DEF  = 64;
   localparam int OUT_WIDTH_DEF = 512;

   // A single-beat frame still needs a one-bit counter port.
   function automatic int cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

   localparam int BEATS_DEF = OUT_WIDTH_DEF / IN_WIDTH_DEF;
   localparam int CNT_W_DEF = cnt_width(BEATS_DEF);

endpackage

// File: rtl/input_deserializer_beat_counter.sv
// Beat position within the frame being assembled; wraps after the last beat
// and flags when the current position is the final one.
module input_deserializer_beat_counter
   import input_deserializer_pkg::*;
#(
   parameter int BEATS = BEATS_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o,
   output logic             last_o
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign last_o  = (count_q == LAST_IDX);
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = last_o ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clr_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/input_deserializer.sv
// Packs BEATS host beats into one wide frame: an assembly register feeds an
// output holding register, each side with its own valid/ready handshake.
module input_deserializer
   import input_deserializer_pkg::*;
#(
   parameter  int IN_WIDTH  = IN_WIDTH_DEF,
   parameter  int OUT_WIDTH = OUT_WIDTH_DEF,
   localparam int BEATS     = OUT_WIDTH / IN_WIDTH,
   localparam int CNT_W     = cnt_width(BEATS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 src_valid,
   output logic                 src_ready,
   input  logic [IN_WIDTH-1:0]  src_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]     beat_count,
   output logic                 frame_done
);

   logic [OUT_WIDTH-1:0] asm_q, asm_d;
   logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
   logic                 asm_full_q, asm_full_d;
   logic                 out_valid_q, out_valid_d;
   logic                 src_ready_q;
   logic                 frame_done_q;
   logic                 accept;
   logic                 last_beat;
   logic                 transfer;

   assign accept   = src_valid && src_ready_q;
   // Output register is free when empty or being drained this same edge.
   assign transfer = asm_full_q && (!out_valid_q || out_ready);

   input_deserializer_beat_counter #(
      .BEATS (BEATS),
      .CNT_W (CNT_W)
   ) u_beat_counter (
      .clk     (clk),
      .clr_i   (reset),
      .en_i    (accept),
      .count_o (beat_count),
      .last_o  (last_beat)
   );

   always_comb begin
      asm_d       = asm_q;
      asm_full_d  = asm_full_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         for (int k = 0; k < BEATS; k++) begin
            if (beat_count == CNT_W'(k)) begin
               asm_d[k*IN_WIDTH +: IN_WIDTH] = src_data;
            end
         end
         if (last_beat) begin
            asm_full_d = 1'b1;
         end
      end
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      // A transfer overrides the drain so the new frame follows without a gap.
      if (transfer) begin
         out_data_d  = asm_q;
         out_valid_d = 1'b1;
         asm_full_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         asm_q        <= '0;
         asm_full_q   <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         src_ready_q  <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         asm_q        <= asm_d;
         asm_full_q   <= asm_full_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         src_ready_q  <= !asm_full_d;
         frame_done_q <= transfer;
      end
   end

   assign src_ready  = src_ready_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_input_deserializer.sv
// Directed bench for input_deserializer: framing, streaming, backpressure,
// gapped input, mid-frame reset and ignored beats while not ready.
module tb_input_deserializer;

   localparam int IW = 64;
   localparam int OW = 512;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          src_valid;
   logic          src_ready;
   logic [IW-1:0] src_data;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic [CW-1:0] beat_count;
   logic          frame_done;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   input_deserializer #(
      .IN_WIDTH  (IW),
      .OUT_WIDTH (OW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .src_data   (src_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .beat_count (beat_count),
      .frame_done (frame_done)
   );

   // Advance one clock edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected frame whose beat i carries base+i, beat 0 in the LSBs.
   function automatic logic [OW-1:0] mkframe(input logic [IW-1:0] base);
      logic [OW-1:0] f;
      f = '0;
      for (int i = 0; i < 8; i++) f[i*IW +: IW] = base + IW'(i);
      return f;
   endfunction

   task automatic test_reset();
      reset = 1'b1; src_valid = 1'b0; src_data = '0; out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      n_vec++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL rst_src_ready got=%b exp=1", src_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
      n_vec++; if (beat_count !== 3'd0) begin n_err++; $display("FAIL rst_beat_count got=%0d exp=0", beat_count); end
      n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done got=%b exp=0", frame_done); end
   endtask

   task automatic test_single_frame();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         src_valid = 1'b1; src_data = IW'(i);
         tick();
         n_vec++; if (beat_count !== CW'((i + 1) % 8)) begin n_err++; $display("FAIL single_cnt beat=%0d got=%0d exp=%0d", i, beat_count, (i + 1) % 8); end
         if (i < 7) begin
            n_vec++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_early beat=%0d got=%b exp=1", i, src_ready); end
         end
      end
      src_valid = 1'b0;
      n_vec++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL single_ready_drop got=%b exp=0", src_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_ovalid_early got=%b exp=0", out_valid); end
      n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL single_fd_early got=%b exp=0", frame_done); end
      tick();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_ovalid got=%b exp=1", out_valid); end
      n_vec++; if (frame_done !== 1'b1) begin n_err++; $display("FAIL single_fd got=%b exp=1", frame_done); end
      n_vec++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_back got=%b exp=1", src_ready); end
      n_vec++; if (out_data[63:0] !== 64'h0) begin n_err++; $display("FAIL single_lsb got=%h exp=0", out_data[63:0]); end
      n_vec++; if (out_data[511:448] !== 64'h7) begin n_err++; $display("FAIL single_msb got=%h exp=7", out_data[511:448]); end
      n_vec++; if (out_data !== mkframe(64'h0)) begin n_err++; $display("FAIL single_frame got=%h", out_data); end
      tick();
      n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL single_fd_width got=%b exp=0", frame_done); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_streaming();
      int b = 0;
      int frames = 0;
      logic rdy_before;
      logic fd_prev = 1'b0;
      out_ready = 1'b1;
      src_valid = 1'b1;
      for (int cyc = 0; cyc < 27; cyc++) begin
         src_data = 64'hA000 + IW'(b);
         rdy_before = src_ready;
         tick();
         if (rdy_before) b++;
         if (frame_done) begin
            n_vec++; if (fd_prev) begin n_err++; $display("FAIL stream_fd_width cyc=%0d got=2+ cycles exp=1", cyc); end
            n_vec++; if (cyc !== frames * 9 + 8) begin n_err++; $display("FAIL stream_fd_time got=%0d exp=%0d", cyc, frames * 9 + 8); end
            n_vec++; if (out_data !== mkframe(64'hA000 + IW'(frames * 8))) begin n_err++; $display("FAIL stream_frame%0d got=%h", frames, out_data); end
            frames++;
         end
         fd_prev = frame_done;
      end
      src_valid = 1'b0;
      n_vec++; if (b !== 24) begin n_err++; $display("FAIL stream_beats got=%0d exp=24", b); end
      n_vec++; if (frames !== 3) begin n_err++; $display("FAIL stream_frames got=%0d exp=3", frames); end
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         src_valid = 1'b1; src_data = 64'hB000 + IW'(i);
         tick();
      end
      src_valid = 1'b0;
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_data !== mkframe(64'hB000)) begin n_err++; $display("FAIL bp_frame0 valid=%b data=%h", out_valid, out_data); end
      for (int i = 0; i < 8; i++) begin
         n_vec++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_beat%0d got=%b exp=1", i, src_ready); end
         src_valid = 1'b1; src_data = 64'hB100 + IW'(i);
         tick();
      end
      n_vec++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_fall got=%b exp=0", src_ready); end
      n_vec++; if (beat_count !== 3'd0) begin n_err++; $display("FAIL bp_cnt got=%0d exp=0", beat_count); end
      // Beats offered while not ready must vanish.
      src_data = 64'hDEAD;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready got=%b exp=0", src_ready); end
         n_vec++; if (out_valid !== 1'b1 || out_data !== mkframe(64'hB000)) begin n_err++; $display("FAIL bp_hold_data valid=%b data=%h", out_valid, out_data); end
         n_vec++; if (beat_count !== 3'd0 || frame_done !== 1'b0) begin n_err++; $display("FAIL bp_hold_ctl cnt=%0d fd=%b exp=0/0", beat_count, frame_done); end
      end
      out_ready = 1'b1;
      tick();
      src_valid = 1'b0; out_ready = 1'b0;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_swap_valid got=%b exp=1", out_valid); end
      n_vec++; if (out_data !== mkframe(64'hB100)) begin n_err++; $display("FAIL bp_swap_data got=%h", out_data); end
      n_vec++; if (frame_done !== 1'b1 || src_ready !== 1'b1) begin n_err++; $display("FAIL bp_swap_ctl fd=%b rdy=%b exp=1/1", frame_done, src_ready); end
      tick();
      n_vec++; if (out_data !== mkframe(64'hB100) || beat_count !== 3'd0) begin n_err++; $display("FAIL bp_after data=%h cnt=%0d", out_data, beat_count); end
      out_ready = 1'b1;
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_gaps();
      int k = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 16; cyc++) begin
         src_valid = (cyc % 2 == 0);
         src_data = src_valid ? 64'hC000 + IW'(k) : 64'hBAD0 + IW'(cyc);
         tick();
         if (src_valid) k++;
         if (cyc < 15) begin
            n_vec++; if (beat_count !== CW'(k % 8)) begin n_err++; $display("FAIL gap_cnt cyc=%0d got=%0d exp=%0d", cyc, beat_count, k % 8); end
         end
      end
      src_valid = 1'b0;
      n_vec++; if (frame_done !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL gap_done fd=%b valid=%b exp=1/1", frame_done, out_valid); end
      n_vec++; if (out_data !== mkframe(64'hC000)) begin n_err++; $display("FAIL gap_frame got=%h", out_data); end
      tick();
   endtask

   task automatic test_reset_midframe();
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         src_valid = (i < 8); src_data = 64'hD000 + IW'(i);
         tick();
      end
      for (int i = 0; i < 5; i++) begin
         src_valid = 1'b1; src_data = 64'hE000 + IW'(i);
         tick();
      end
      n_vec++; if (beat_count !== 3'd5 || out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre cnt=%0d valid=%b exp=5/1", beat_count, out_valid); end
      src_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      n_vec++; if (beat_count !== 3'd0) begin n_err++; $display("FAIL mid_cnt got=%0d exp=0", beat_count); end
      n_vec++; if (out_valid !== 1'b0 || out_data !== '0) begin n_err++; $display("FAIL mid_out valid=%b data=%h exp=0", out_valid, out_data); end
      n_vec++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got=%b exp=1", src_ready); end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         src_valid = 1'b1; src_data = 64'hF000 + IW'(i);
         tick();
      end
      src_valid = 1'b0;
      tick();
      n_vec++; if (frame_done !== 1'b1 || out_data !== mkframe(64'hF000)) begin n_err++; $display("FAIL mid_clean fd=%b data=%h", frame_done, out_data); end
      tick();
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_streaming();
      test_backpressure();
      test_gaps();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=no_finish exp=finish");
      $fatal(1, "timeout");
   end

endmodule
